// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared drain FSM state type and default word width
package systolic_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        STREAM = 2'd2
    } drain_state_t;

endpackage

// File: rtl/systolic_row_drain.sv
// rtl/systolic_row_drain.sv - east-edge row drain: gather column accumulators, stream in column order
// Optional SELECT watchdog enabled by defining SYSTOLIC_DRAIN_TIMEOUT_EN.
module systolic_row_drain
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int N_COLS        = 4,
    parameter int DRAIN_TIMEOUT = 15
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic [N_COLS*DATA_WIDTH-1:0] acc_data_i,
    input  logic [N_COLS-1:0]            acc_valid_i,
    input  logic [N_COLS-1:0]            last_element_i,
    output logic                         select_accumulator_o,
    output logic [DATA_WIDTH-1:0]        out_data_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         out_last_o,
    output logic                         busy_o,
    output logic                         error_o
);

    localparam int IDX_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_COLS - 1);

    drain_state_t          state_q, state_d;
    logic [N_COLS-1:0]     last_mask_q, last_mask_d;
    logic [N_COLS-1:0]     cap_mask_q, cap_mask_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] buf_q [N_COLS];
    logic [DATA_WIDTH-1:0] buf_d [N_COLS];

    logic                  sel_q, sel_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic cap_full_d;
    logic timeout_hit;
    logic handshake;

    assign handshake  = valid_q & out_ready_i;
    assign cap_full_d = &cap_mask_d;

    // Masks, capture buffer and stream index
    always_comb begin
        last_mask_d = last_mask_q | last_element_i;
        cap_mask_d  = cap_mask_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        case (state_q)
            IDLE: begin
                // Entering SELECT: keep only pulses of this very cycle for the next round,
                // and wipe stale words so uncaptured columns read as zero.
                if (&last_mask_q) begin
                    last_mask_d = last_element_i;
                    for (int c = 0; c < N_COLS; c++) begin
                        buf_d[c] = '0;
                    end
                end
            end
            SELECT: begin
                for (int c = 0; c < N_COLS; c++) begin
                    if (acc_valid_i[c] && !cap_mask_q[c]) begin
                        cap_mask_d[c] = 1'b1;
                        buf_d[c]      = acc_data_i[c*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            STREAM: begin
                if (handshake) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d      = '0;
                        cap_mask_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (&last_mask_q) state_d = SELECT;
            SELECT:  if (cap_full_d || timeout_hit) state_d = STREAM;
            STREAM:  if (handshake && idx_q == IDX_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs, computed from the next state and registered below
    always_comb begin
        sel_d   = (state_d == SELECT);
        valid_d = (state_d == STREAM);
        busy_d  = (state_d != IDLE);
        last_d  = valid_d && (idx_d == IDX_LAST);
        data_d  = valid_d ? buf_d[idx_d] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            last_mask_q <= '0;
            cap_mask_q  <= '0;
            idx_q       <= '0;
            for (int c = 0; c < N_COLS; c++) begin
                buf_q[c] <= '0;
            end
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            last_mask_q <= last_mask_d;
            cap_mask_q  <= cap_mask_d;
            idx_q       <= idx_d;
            buf_q       <= buf_d;
            sel_q       <= sel_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            data_q      <= data_d;
        end
    end

`ifdef SYSTOLIC_DRAIN_TIMEOUT_EN
    localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 1);

    logic [CNT_W-1:0] sel_cnt_q;
    logic             error_q;

    // Counter holds the number of completed SELECT cycles; gives up on the last one.
    assign timeout_hit = (state_q == SELECT) && !cap_full_d
                         && (sel_cnt_q == CNT_W'(DRAIN_TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sel_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            sel_cnt_q <= (state_q == SELECT) ? sel_cnt_q + 1'b1 : '0;
            error_q   <= error_q | timeout_hit;
        end
    end

    assign error_o = error_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (DRAIN_TIMEOUT == 0);
    assign timeout_hit        = 1'b0;
    assign error_o            = 1'b0;
`endif

    assign select_accumulator_o = sel_q;
    assign out_valid_o          = valid_q;
    assign out_last_o           = last_q;
    assign busy_o               = busy_q;
    assign out_data_o           = data_q;

endmodule

// File: tb/tb_systolic_row_drain.sv
// tb/tb_systolic_row_drain.sv - directed self-checking bench for systolic_row_drain
module tb_systolic_row_drain;

    localparam int DW = 32;
    localparam int NC = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic [NC*DW-1:0] acc_data;
    logic [NC-1:0]    acc_valid;
    logic [NC-1:0]    last_el;
    logic             sel;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             error;

    int checks = 0;
    int errors = 0;

    systolic_row_drain #(.DATA_WIDTH(DW), .N_COLS(NC), .DRAIN_TIMEOUT(15)) dut (
        .clk_i               (clk),
        .rstn_i              (rstn),
        .acc_data_i          (acc_data),
        .acc_valid_i         (acc_valid),
        .last_element_i      (last_el),
        .select_accumulator_o(sel),
        .out_data_o          (out_data),
        .out_valid_o         (out_valid),
        .out_ready_i         (out_ready),
        .out_last_o          (out_last),
        .busy_o              (busy),
        .error_o             (error)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic word(input string tag, input logic [31:0] exp_data, input logic exp_last);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_data"}, out_data, exp_data);
        chk({tag, "_last"}, out_last, exp_last);
        step();
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_sel"}, sel, 1'b0);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_last"}, out_last, 1'b0);
        chk({tag, "_data"}, out_data, 32'h0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_error"}, error, 1'b0);
    endtask

    initial begin
        rstn      = 1'b0;
        acc_data  = '0;
        acc_valid = '0;
        last_el   = '0;
        out_ready = 1'b0;
        step();
        step();
        rstn = 1'b1;
        reset_outputs("rst");

        // Round 1: staggered last pulses, all PEs answer together
        last_el = 4'b0001; step();
        last_el = 4'b0010; step();
        last_el = 4'b0100; step();
        last_el = 4'b1000; step();
        last_el = 4'b0000;
        chk("r1_sel_pre", sel, 1'b0);
        step();
        chk("r1_sel", sel, 1'b1);
        chk("r1_busy", busy, 1'b1);
        chk("r1_valid_in_sel", out_valid, 1'b0);
        acc_data  = {32'h44, 32'h33, 32'h22, 32'h11};
        acc_valid = 4'b1111;
        step();
        acc_valid = 4'b0000;
        acc_data  = {4{32'hDEAD_BEEF}};
        out_ready = 1'b1;
        chk("r1_sel_drop", sel, 1'b0);
        word("r1_w0", 32'h11, 1'b0);
        word("r1_w1", 32'h22, 1'b0);
        word("r1_w2", 32'h33, 1'b0);
        word("r1_w3", 32'h44, 1'b1);
        chk("r1_idle_valid", out_valid, 1'b0);
        chk("r1_idle_busy", busy, 1'b0);

        // Round 2: staggered capture, repeat valid ignored, backpressure on word 1
        out_ready = 1'b0;
        last_el   = 4'b1111; step();
        last_el   = 4'b0000; step();
        chk("r2_sel", sel, 1'b1);
        acc_data  = {32'h0, 32'hC2, 32'h0, 32'h0};
        acc_valid = 4'b0100; step();
        acc_valid = 4'b0000; step();
        acc_data  = {32'h0, 32'h0, 32'h0, 32'hC0};
        acc_valid = 4'b0001; step();
        acc_data  = {32'h0, 32'hEE, 32'h0, 32'h0};
        acc_valid = 4'b0100; step();
        acc_valid = 4'b0000; step();
        chk("r2_sel_wait", sel, 1'b1);
        chk("r2_valid_wait", out_valid, 1'b0);
        acc_data  = {32'hC3, 32'h0, 32'hC1, 32'h0};
        acc_valid = 4'b1010; step();
        acc_valid = 4'b0000;
        chk("r2_sel_drop", sel, 1'b0);
        out_ready = 1'b1;
        word("r2_w0", 32'hC0, 1'b0);
        out_ready = 1'b0;
        word("r2_bp0", 32'hC1, 1'b0);
        word("r2_bp1", 32'hC1, 1'b0);
        word("r2_bp2", 32'hC1, 1'b0);
        out_ready = 1'b1;
        word("r2_w1", 32'hC1, 1'b0);
        word("r2_w2", 32'hC2, 1'b0);
        word("r2_w3", 32'hC3, 1'b1);
        chk("r2_idle_valid", out_valid, 1'b0);

        // Round 3: last_element[0] during STREAM carries into next round only
        last_el = 4'b1111; step();
        last_el = 4'b0000; step();
        acc_data  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        acc_valid = 4'b1111; step();
        acc_valid = 4'b0000;
        last_el   = 4'b0001;
        word("r3_w0", 32'hA0, 1'b0);
        last_el   = 4'b0000;
        word("r3_w1", 32'hA1, 1'b0);
        word("r3_w2", 32'hA2, 1'b0);
        word("r3_w3", 32'hA3, 1'b1);
        chk("r3_idle_busy", busy, 1'b0);
        step();
        chk("r3_partial_sel0", sel, 1'b0);
        step();
        chk("r3_partial_sel1", sel, 1'b0);
        last_el = 4'b1110; step();
        last_el = 4'b0000;
        chk("r4_sel_pre", sel, 1'b0);
        step();
        chk("r4_sel", sel, 1'b1);

        // Round 4: reset two cycles into STREAM
        acc_data  = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        acc_valid = 4'b1111; step();
        acc_valid = 4'b0000;
        chk("r4_w0", out_data, 32'hB0);
        step();
        step();
        chk("r4_w2", out_data, 32'hB2);
        rstn = 1'b0; step();
        reset_outputs("midrst");
        rstn = 1'b1; step();
        chk("postrst_sel0", sel, 1'b0);
        step();
        chk("postrst_sel1", sel, 1'b0);

        // Round 5: fresh data after reset
        last_el = 4'b1111; step();
        last_el = 4'b0000; step();
        chk("r5_sel", sel, 1'b1);
        acc_data  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        acc_valid = 4'b1111; step();
        acc_valid = 4'b0000;
        word("r5_w0", 32'hD0, 1'b0);
        word("r5_w1", 32'hD1, 1'b0);
        word("r5_w2", 32'hD2, 1'b0);
        word("r5_w3", 32'hD3, 1'b1);
        chk("r5_idle_valid", out_valid, 1'b0);

`ifdef SYSTOLIC_DRAIN_TIMEOUT_EN
        // Round 6: column 3 never answers; watchdog after 15 SELECT cycles
        last_el = 4'b1111; step();
        last_el = 4'b0000; step();
        chk("to_sel", sel, 1'b1);
        acc_data  = {32'h0, 32'hE2, 32'hE1, 32'hE0};
        acc_valid = 4'b0111; step();
        acc_valid = 4'b0000;
        for (int i = 0; i < 13; i++) step();
        chk("to_sel_last", sel, 1'b1);
        chk("to_err_pre", error, 1'b0);
        step();
        chk("to_err", error, 1'b1);
        chk("to_sel_drop", sel, 1'b0);
        word("to_w0", 32'hE0, 1'b0);
        word("to_w1", 32'hE1, 1'b0);
        word("to_w2", 32'hE2, 1'b0);
        word("to_w3", 32'h0, 1'b1);
        chk("to_err_sticky", error, 1'b1);
        chk("to_idle_valid", out_valid, 1'b0);
`else
        chk("err_tied", error, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_row_drain.md
# systolic_row_drain

Per-row drain controller at the east edge of the systolic array; the consumer of every PE's accumulator output in one row. It tracks each column's end-of-computation pulse, then asserts the accumulator-select control to the whole row. It captures each column's accumulator word when that column's accumulator-valid fires, and streams the captured words out in column order on a valid/ready interface.

## Interface
- DATA_WIDTH, 32, width of one accumulator word
- N_COLS, 4, number of PEs in the row (≥1)
- DRAIN_TIMEOUT, 15, max cycles in SELECT before error (only with timeout feature)
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  reset; one clock; reset is synchronous and active-low
- acc_data_i  in  N_COLS*DATA_WIDTH  PE east outputs; column c at [c*DATA_WIDTH +: DATA_WIDTH]
- acc_valid_i  in  N_COLS  per-column accumulator-valid
- last_element_i  in  N_COLS  per-column last-element pulse
- select_accumulator_o  out  1  broadcast to all PEs of the row
- out_data_o  out  DATA_WIDTH  streamed accumulator word
- out_valid_o  out  1  out_data_o valid
- out_ready_i  in  1  downstream accepts
- out_last_o  out  1  marks column N_COLS-1 word
- busy_o  out  1  high in SELECT or STREAM
- error_o  out  1  sticky timeout flag

## Operation
- States: IDLE, SELECT, STREAM.
- last_mask[N_COLS] is sticky. Bit c sets on last_element_i[c] in any state. A repeat pulse on a set bit has no effect.
- IDLE -> SELECT when last_mask is all ones, evaluated on the registered mask.
- On that transition, last_mask clears. Pulses arriving in the same cycle, or during SELECT or STREAM, are kept for the next round.
- SELECT: select_accumulator_o=1.
  - cap_mask[c] sets and buf[c] <= acc_data_i slice c when acc_valid_i[c]=1 and cap_mask[c]=0. Later valids on a captured column are ignored.
  - SELECT -> STREAM when cap_mask is all ones, including a mask completed this cycle.
  - select_accumulator_o drops in the same registered update.
- STREAM: out_valid_o=1 and out_data_o=buf[idx], idx starting at 0.
  - On out_valid_o&out_ready_i: idx increments.
  - out_last_o=1 when idx==N_COLS-1.
  - Handshake on the last word -> IDLE; idx and cap_mask clear.
- out_data_o stays stable while out_valid_o=1 and out_ready_i=0. out_valid_o never drops without a handshake.
- acc_valid_i outside SELECT is ignored.

## Timing
- All outputs are registered.
- Reset values: select_accumulator_o=0, out_valid_o=0, out_last_o=0, out_data_o=0, busy_o=0, error_o=0. Reset also sets state IDLE and clears both masks, idx and buf.
- Reset mid-drain takes priority over everything. It aborts SELECT/STREAM and discards captured data.
- Example sequence:
  - Final last_element pulse sampled at edge T: last_mask full after T.
  - Edge T+1: state=SELECT, select_accumulator_o=1.
  - An idle PE answers at T+2 (acc_valid_i high after edge T+2).
  - Edge T+3: capture; state=STREAM, select_accumulator_o=0, out_valid_o=1 with buf[0].
- With continuous ready, words go out on consecutive cycles. N_COLS words take N_COLS cycles. The next round may enter SELECT the cycle after return to IDLE.
- idx width is $clog2(N_COLS) with a minimum of 1. It never wraps past N_COLS-1.

## Configuration
- SYSTOLIC_DRAIN_TIMEOUT_EN defined:
  - A cycle counter runs in SELECT.
  - If cap_mask is not full after DRAIN_TIMEOUT cycles, error_o sets sticky until reset.
  - The FSM then goes to STREAM. Uncaptured columns stream as 0.
- Not defined: no counter; error_o is tied 0; SELECT waits indefinitely.

## Structure
- Shared package systolic_pkg holds drain_state_t (IDLE=2'd0, SELECT=2'd1, STREAM=2'd2) and the default DATA_WIDTH constant.
- No sub-module. The capture buffer, masks and output mux stay inline; RTL is roughly 150–250 lines.

## Test plan
- N_COLS=4. Pulse last_element_i columns 0..3 on separate cycles, then PEs return 0x11,0x22,0x33,0x44 on the same cycle, ready=1 -> select_accumulator_o asserted exactly 1 cycle after the 4th pulse. Stream is 0x11,0x22,0x33,0x44 on 4 consecutive cycles, out_last_o only on 0x44.
- Staggered acc_valid_i: col2 at +0, col0 at +2, cols 1/3 at +5 -> capture order is irrelevant; output is still column order; STREAM begins the cycle after col1/col3 capture.
- Backpressure: ready low for 3 cycles on word 1 -> out_data_o is held at word 1 and out_valid_o stays high. No word is lost or duplicated.
- last_element_i[0] pulsed during STREAM -> current stream is unaffected. After return to IDLE, only col0 is set; SELECT starts only after cols 1–3 also pulse.
- Reset asserted 2 cycles into STREAM -> next cycle all outputs are at reset values, and the following round captures fresh data.
- With SYSTOLIC_DRAIN_TIMEOUT_EN, DRAIN_TIMEOUT=15, col3 never valid -> error_o=1 after 15 SELECT cycles; the stream ends with word 3 = 0 and out_last_o=1.
